pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed EX/MEM-style latch between core stages. It carries a data word plus register-write control (write enable and destination register), sustains full throughput under back-pressure, supports a synchronous flush, and exposes a forwarding tap for the hazard unit. It is instantiated at the EX→MEM and MEM→WB boundaries of the RISC-V pipeline.

## Interface
- DATA_W, 32, payload width (ALU result or load data)
- RD_W, 5, destination register index width
- CNT_W, 16, width of statistics counters
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  synchronous, active-high; discards all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered (function of state only)
- in_data  in  DATA_W  payload
- in_wr  in  1  register-write enable
- in_rd  in  RD_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_data  out  DATA_W  head payload
- out_wr  out  1  head write enable, gated by out_valid
- out_rd  out  RD_W  head destination register
- fwd_valid  out  1  out_valid & out_wr
- fwd_rd  out  RD_W  equals out_rd
- fwd_data  out  DATA_W  equals out_data
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
- flush_cnt  out  CNT_W  flushes that discarded ≥1 entry

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register. States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
- EMPTY: in_fire → ONE, main ← in.
- ONE: in_fire & out_fire → ONE, main ← in; in_fire only → TWO, skid ← in; out_fire only → EMPTY.
- TWO: out_fire → ONE, main ← skid; otherwise hold. in_ready = 0 in TWO and 1 in EMPTY/ONE.
- x0 rule: an entry captured with in_rd == 0 stores wr = 0 regardless of in_wr.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over everything. Next state is EMPTY, main/skid data, wr and rd are cleared to 0, and an in_fire in the same cycle is discarded. in_ready is 1 the cycle after the flush.
- out_data/out_rd hold the cleared value (0) when out_valid = 0. out_wr = 0 whenever out_valid = 0.
- Reset values: in_ready 0 while reset is asserted and 1 from the first clock after release. All other outputs are 0: out_valid, out_data, out_wr, out_rd, fwd_*, occupancy, stall_cnt, flush_cnt.
- Reset mid-operation clears both entries immediately (asynchronous). Release is synchronised to clk by the integrator.

## Timing
- Latency: in_fire at edge N → out_valid at edge N+1 (from EMPTY, or from ONE with a simultaneous out_fire).
- Throughput: one entry per cycle when out_ready = 1 continuously.
- in_ready has no combinational path from out_ready or in_valid. The skid absorbs the one in-flight entry.
- out_* and fwd_* are driven directly from flops. There is no combinational input→output path.
- The flush at edge N takes effect at edge N: out_valid is 0 after edge N.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt and flush_cnt are live.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments on a flush when occupancy != 0.
  - Both counters saturate at all-ones and clear only on reset; flush does not clear them.
- PIPE_STAGE_STATS_EN undefined: the ports remain, are driven constant 0, and no counter flops are synthesised.

## Test plan
- Streaming: out_ready = 1, send 0x11, 0x22, 0x33 (rd = 1, 2, 3, wr = 1) on consecutive cycles → each appears one cycle later, in order, occupancy ≤ 1, in_ready stays 1.
- Back-pressure: out_ready = 0, send 0xA0 then 0xB0 → occupancy 2, in_ready = 0. A third offer of 0xC0 is not accepted. Raise out_ready → 0xA0, 0xB0, 0xC0 emerge in order.
- Flush: hold two entries, assert flush together with in_valid = 1 (0xDD) → next cycle out_valid = 0, occupancy 0, in_ready = 1, and 0xDD never appears. With the macro, flush_cnt = 1.
- x0 rule: send in_wr = 1, in_rd = 0, in_data = 0x55 → out_valid = 1, out_wr = 0, fwd_valid = 0.
- Async reset mid-stream: with occupancy 2, pulse reset low between edges → all outputs 0 immediately, in_ready = 0 during reset, and 1 one clock after release.
- Stats: with the macro, out_ready = 0 for 5 cycles with out_valid = 1 → stall_cnt = 5. Without the macro, stall_cnt = 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to enable the stall/flush statistics counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wr,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wr,
    output logic [RD_W-1:0]   out_rd,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic              main_wr, skid_wr;
    logic              ready_q, valid_q;
    logic              in_fire, out_fire, cap_wr;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = valid_q & out_ready;
    // Writes to x0 are architecturally dropped, so never advertise them.
    assign cap_wr   = in_wr & (in_rd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_rd   <= '0;
            main_wr   <= 1'b0;
            skid_data <= '0;
            skid_rd   <= '0;
            skid_wr   <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            main_data <= '0;
            main_rd   <= '0;
            main_wr   <= 1'b0;
            skid_data <= '0;
            skid_rd   <= '0;
            skid_wr   <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (in_fire) begin
                        state     <= ONE;
                        main_data <= in_data;
                        main_rd   <= in_rd;
                        main_wr   <= cap_wr;
                        valid_q   <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data <= in_data;
                        main_rd   <= in_rd;
                        main_wr   <= cap_wr;
                    end else if (in_fire) begin
                        state     <= TWO;
                        skid_data <= in_data;
                        skid_rd   <= in_rd;
                        skid_wr   <= cap_wr;
                        ready_q   <= 1'b0;
                    end else if (out_fire) begin
                        // Head drains to the cleared value so outputs read 0 when idle.
                        state     <= EMPTY;
                        main_data <= '0;
                        main_rd   <= '0;
                        main_wr   <= 1'b0;
                        valid_q   <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        main_rd   <= skid_rd;
                        main_wr   <= skid_wr;
                        skid_data <= '0;
                        skid_rd   <= '0;
                        skid_wr   <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // main_wr is only ever set while the head is valid, so it is already gated.
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_data;
    assign out_rd    = main_rd;
    assign out_wr    = main_wr;
    assign fwd_valid = main_wr;
    assign fwd_rd    = main_rd;
    assign fwd_data  = main_data;
    assign occupancy = state;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (valid_q && !out_ready && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (flush && state != EMPTY && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
